// File: rtl/imem_loader_if.sv
// Byte-stream, load-control and core instruction-fetch signals of the
// instruction memory loader, grouped with source (master) and loader (slave) views.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              load_req;
    logic [ADDR_W-1:0] iaddr;
    logic [15:0]       idata;
    logic              cpu_reset;
    logic              load_err;
    logic [ADDR_W:0]   loaded_len;

    modport master (
        output rx_valid, rx_data, load_req, iaddr,
        input  rx_ready, idata, cpu_reset, load_err, loaded_len
    );

    modport slave (
        input  rx_valid, rx_data, load_req, iaddr,
        output rx_ready, idata, cpu_reset, load_err, loaded_len
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction RAM owner for the forth core: loads a checksummed framed byte image
// into RAM and holds the core in reset until a valid image is present.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DEPTH     = 2 ** ADDR_W,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] NOP_WORD  = 16'hE040
) (
    input logic          clk,
    input logic          reset_n,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        StSync, StLenLo, StLenHi, StDataLo, StDataHi, StCsum, StRun, StError
    } state_e;

    localparam logic [ADDR_W:0] WpOne = 1;

    state_e            r_state;
    logic [7:0]        r_len_lo;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_wp;
    logic [7:0]        r_lo;
    logic [7:0]        r_csum;
    logic [ADDR_W:0]   r_loaded_len;
    logic [15:0]       r_idata;
    logic [15:0]       r_mem [DEPTH];

    state_e            w_state_next;
    logic [7:0]        w_len_lo_next;
    logic [ADDR_W:0]   w_len_next;
    logic [ADDR_W:0]   w_wp_next;
    logic [ADDR_W:0]   w_wp_inc;
    logic [7:0]        w_lo_next;
    logic [7:0]        w_csum_next;
    logic [ADDR_W:0]   w_loaded_len_next;
    logic [15:0]       w_n;
    logic              w_fire;
    logic              w_we;
    logic [15:0]       w_wdata;
    logic              w_rx_ready;
    logic              w_cpu_reset;

    assign w_rx_ready  = (r_state != StRun) && (r_state != StError);
    assign w_cpu_reset = (r_state != StRun);
    // load_req wins over a same-cycle byte, which is simply dropped
    assign w_fire      = bus.rx_valid && w_rx_ready && !bus.load_req;
    assign w_n         = {bus.rx_data, r_len_lo};
    assign w_wp_inc    = r_wp + WpOne;
    assign w_wdata     = {bus.rx_data, r_lo};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StSync;
            r_len_lo     <= 8'h00;
            r_len        <= '0;
            r_wp         <= '0;
            r_lo         <= 8'h00;
            r_csum       <= 8'h00;
            r_loaded_len <= '0;
        end else begin
            r_state      <= w_state_next;
            r_len_lo     <= w_len_lo_next;
            r_len        <= w_len_next;
            r_wp         <= w_wp_next;
            r_lo         <= w_lo_next;
            r_csum       <= w_csum_next;
            r_loaded_len <= w_loaded_len_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_len_lo_next     = r_len_lo;
        w_len_next        = r_len;
        w_wp_next         = r_wp;
        w_lo_next         = r_lo;
        w_csum_next       = r_csum;
        w_loaded_len_next = r_loaded_len;
        w_we              = 1'b0;
        if (bus.load_req) begin
            w_state_next      = StSync;
            w_loaded_len_next = '0;
        end else if (w_fire) begin
            case (r_state)
                StSync: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        w_state_next = StLenLo;
                        w_csum_next  = 8'h00;
                    end
                end
                StLenLo: begin
                    w_len_lo_next = bus.rx_data;
                    w_csum_next   = r_csum ^ bus.rx_data;
                    w_state_next  = StLenHi;
                end
                StLenHi: begin
                    w_csum_next = r_csum ^ bus.rx_data;
                    if (32'(w_n) > DEPTH) begin
                        w_state_next = StError;
                    end else begin
                        w_len_next   = w_n[ADDR_W:0];
                        w_wp_next    = '0;
                        w_state_next = (w_n == 16'h0000) ? StCsum : StDataLo;
                    end
                end
                StDataLo: begin
                    w_lo_next    = bus.rx_data;
                    w_csum_next  = r_csum ^ bus.rx_data;
                    w_state_next = StDataHi;
                end
                StDataHi: begin
                    w_we         = 1'b1;
                    w_csum_next  = r_csum ^ bus.rx_data;
                    w_wp_next    = w_wp_inc;
                    w_state_next = (w_wp_inc == r_len) ? StCsum : StDataLo;
                end
                StCsum: begin
                    if (bus.rx_data == r_csum) begin
                        w_state_next      = StRun;
                        w_loaded_len_next = r_len;
                    end else begin
                        w_state_next = StError;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wp[ADDR_W-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idata <= NOP_WORD;
        end else if (w_cpu_reset || ({1'b0, bus.iaddr} >= r_loaded_len)) begin
            r_idata <= NOP_WORD;
        end else begin
            r_idata <= r_mem[bus.iaddr];
        end
    end

    assign bus.rx_ready   = w_rx_ready;
    assign bus.cpu_reset  = w_cpu_reset;
    assign bus.load_err   = (r_state == StError);
    assign bus.loaded_len = r_loaded_len;
    assign bus.idata      = r_idata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of frames with expected end state and
// expected instruction reads, plus hand-written abort and async-reset sequences.
module tb_imem_loader;

    typedef struct packed {
        logic        gap;
        logic        exp_rst;
        logic        exp_err;
        logic [10:0] exp_len;
    } sc_t;

    typedef struct packed {
        logic [2:0]  sc;
        logic [9:0]  addr;
        logic [15:0] exp;
    } rd_t;

    localparam int NSC = 6;
    localparam int NRD = 15;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_bad = 0;

    logic [7:0] fb [NSC][16];
    int         fn [NSC];
    sc_t        sc [NSC];
    rd_t        rd [NRD];

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader #(.ADDR_W(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input int idx, input int n, input logic [127:0] pb);
        fn[idx] = n;
        for (int i = 0; i < 16; i++) begin
            fb[idx][i] = (i < n) ? pb[8*(n-1-i) +: 8] : 8'h00;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        chk("rx_ready_before_byte", {31'd0, bus.rx_ready}, 32'd1);
        tick();
        if (gap) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'hA5;
            tick();
        end
    endtask

    task automatic pulse_load_req(input logic with_byte, input logic [7:0] b);
        bus.load_req = 1'b1;
        bus.rx_valid = with_byte;
        bus.rx_data  = b;
        tick();
        bus.load_req = 1'b0;
        bus.rx_valid = 1'b0;
        chk("load_req_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("load_req_load_err", {31'd0, bus.load_err}, 32'd0);
        chk("load_req_loaded_len", {21'd0, bus.loaded_len}, 32'd0);
        chk("load_req_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    endtask

    initial begin
        set_frame(0, 10, {8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h07, 8'hE0, 8'hE7});
        set_frame(1, 10, {8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h07, 8'hE0, 8'hE6});
        set_frame(2, 13, {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02,
                          8'h00, 8'h07, 8'hE0, 8'hE7});
        set_frame(3, 3, {8'hA5, 8'h01, 8'h04});
        set_frame(4, 4, {8'hA5, 8'h00, 8'h00, 8'h00});
        set_frame(5, 6, {8'hA5, 8'h01, 8'h00, 8'h34, 8'h12, 8'h27});
        //          gap   rst   err   len
        sc[0] = {1'b0, 1'b0, 1'b0, 11'd3};
        sc[1] = {1'b0, 1'b1, 1'b1, 11'd0};
        sc[2] = {1'b1, 1'b0, 1'b0, 11'd3};
        sc[3] = {1'b0, 1'b1, 1'b1, 11'd0};
        sc[4] = {1'b0, 1'b0, 1'b0, 11'd0};
        sc[5] = {1'b0, 1'b0, 1'b0, 11'd1};
        rd[0]  = {3'd0, 10'd0,    16'h0001};
        rd[1]  = {3'd0, 10'd1,    16'h0002};
        rd[2]  = {3'd0, 10'd2,    16'hE007};
        rd[3]  = {3'd0, 10'd5,    16'hE040};
        rd[4]  = {3'd0, 10'd3,    16'hE040};
        rd[5]  = {3'd0, 10'd1023, 16'hE040};
        rd[6]  = {3'd1, 10'd0,    16'hE040};
        rd[7]  = {3'd1, 10'd2,    16'hE040};
        rd[8]  = {3'd2, 10'd2,    16'hE007};
        rd[9]  = {3'd2, 10'd0,    16'h0001};
        rd[10] = {3'd3, 10'd0,    16'hE040};
        rd[11] = {3'd4, 10'd0,    16'hE040};
        rd[12] = {3'd4, 10'd1,    16'hE040};
        rd[13] = {3'd5, 10'd0,    16'h1234};
        rd[14] = {3'd5, 10'd1,    16'hE040};

        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.load_req = 1'b0;
        bus.iaddr    = '0;
        #12;
        chk("reset_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        chk("reset_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("reset_load_err", {31'd0, bus.load_err}, 32'd0);
        chk("reset_loaded_len", {21'd0, bus.loaded_len}, 32'd0);
        chk("reset_idata", {16'd0, bus.idata}, 32'h0000E040);
        #1 reset_n = 1'b1;
        tick();

        for (int s = 0; s < NSC; s++) begin
            if (s > 0) pulse_load_req(1'b0, 8'h00);
            if (s == 5) begin
                // partial frame abandoned; the sync byte offered with load_req must be dropped
                send_byte(8'hA5, 1'b0);
                send_byte(8'h02, 1'b0);
                send_byte(8'h00, 1'b0);
                send_byte(8'h11, 1'b0);
                pulse_load_req(1'b1, 8'hA5);
            end
            for (int i = 0; i < fn[s]; i++) begin
                if (i == fn[s] - 1) chk("cpu_reset_before_last", {31'd0, bus.cpu_reset}, 32'd1);
                send_byte(fb[s][i], sc[s].gap);
            end
            bus.rx_valid = 1'b0;
            chk($sformatf("frame%0d_cpu_reset", s), {31'd0, bus.cpu_reset}, {31'd0, sc[s].exp_rst});
            chk($sformatf("frame%0d_load_err", s), {31'd0, bus.load_err}, {31'd0, sc[s].exp_err});
            chk($sformatf("frame%0d_loaded_len", s), {21'd0, bus.loaded_len},
                {21'd0, sc[s].exp_len});
            chk($sformatf("frame%0d_rx_ready", s), {31'd0, bus.rx_ready}, 32'd0);
            for (int r = 0; r < NRD; r++) begin
                if (int'(rd[r].sc) == s) begin
                    bus.iaddr = rd[r].addr;
                    tick();
                    chk($sformatf("frame%0d_idata_a%0d", s, rd[r].addr), {16'd0, bus.idata},
                        {16'd0, rd[r].exp});
                end
            end
        end

        // async reset from RUN drops idata to NOP without a clock edge
        bus.iaddr = 10'd0;
        tick();
        chk("run_idata_a0", {16'd0, bus.idata}, 32'h00001234);
        #2 reset_n = 1'b0;
        #1;
        chk("async_run_idata", {16'd0, bus.idata}, 32'h0000E040);
        chk("async_run_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("async_run_loaded_len", {21'd0, bus.loaded_len}, 32'd0);
        #2 reset_n = 1'b1;
        tick();

        // async reset while in DATA_HI
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        bus.rx_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_dhi_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("async_dhi_idata", {16'd0, bus.idata}, 32'h0000E040);
        chk("async_dhi_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        chk("async_dhi_load_err", {31'd0, bus.load_err}, 32'd0);
        #2 reset_n = 1'b1;
        tick();
        // back in SYNC: a complete frame must load from scratch
        for (int i = 0; i < fn[5]; i++) send_byte(fb[5][i], 1'b0);
        bus.rx_valid = 1'b0;
        chk("after_reset_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
        chk("after_reset_loaded_len", {21'd0, bus.loaded_len}, 32'd1);
        bus.iaddr = 10'd0;
        tick();
        chk("after_reset_idata_a0", {16'd0, bus.idata}, 32'h00001234);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
